// File: rtl/com_stroke_drawer.sv
// Turns the centre-of-mass point stream into connected canvas strokes: each new
// point is joined to the previous one with a Bresenham line, one pixel per cycle.
module com_stroke_drawer #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int MAX_JUMP = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_com_in,
    input  logic [9:0]  y_com_in,
    input  logic        valid_com_in,
    input  logic        pen_down_in,
    output logic [10:0] pixel_x_out,
    output logic [9:0]  pixel_y_out,
    output logic        pixel_valid_out,
    input  logic        pixel_ready_in,
    output logic        busy_out,
    output logic        drop_out
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

    state_t             state_q, state_d;
    logic [10:0]        last_x_q, last_x_d;
    logic [9:0]         last_y_q, last_y_d;
    logic               have_last_q, have_last_d;
    logic               pend_full_q, pend_full_d;
    logic [10:0]        pend_x_q, pend_x_d;
    logic [9:0]         pend_y_q, pend_y_d;
    logic               pend_pen_q, pend_pen_d;
    logic [10:0]        cur_x_q, cur_x_d, end_x_q, end_x_d;
    logic [9:0]         cur_y_q, cur_y_d, end_y_q, end_y_d;
    logic signed [12:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic               sx_q, sx_d, sy_q, sy_d;
    logic               start_q, start_d;
    logic               drop_q, drop_d;

    // Point source in IDLE: the pending slot has priority over the live strobe.
    logic               take_pend, pt_vld, pt_pen, pt_oor;
    logic [10:0]        pt_x;
    logic [9:0]         pt_y;

    assign take_pend = (state_q == S_IDLE) && pend_full_q;
    assign pt_x      = take_pend ? pend_x_q : x_com_in;
    assign pt_y      = take_pend ? pend_y_q : y_com_in;
    assign pt_pen    = take_pend ? pend_pen_q : pen_down_in;
    assign pt_vld    = (state_q == S_IDLE) && (pend_full_q || valid_com_in);
    assign pt_oor    = ({21'd0, pt_x} >= 32'(H_ACTIVE)) || ({22'd0, pt_y} >= 32'(V_ACTIVE));

    // Segment geometry from cur to end, used in SETUP.
    logic [10:0]        xd_abs;
    logic [9:0]         yd_abs;
    logic signed [12:0] dx_c, dy_c, err_c;
    logic               sx_c, sy_c, glitch, at_end;

    assign sx_c   = (end_x_q >= cur_x_q);
    assign sy_c   = (end_y_q >= cur_y_q);
    assign xd_abs = sx_c ? (end_x_q - cur_x_q) : (cur_x_q - end_x_q);
    assign yd_abs = sy_c ? (end_y_q - cur_y_q) : (cur_y_q - end_y_q);
    assign dx_c   = $signed({2'b00, xd_abs});
    assign dy_c   = -$signed({3'b000, yd_abs});
    assign err_c  = dx_c + dy_c;
    assign glitch = ({21'd0, xd_abs} > 32'(MAX_JUMP)) || ({22'd0, yd_abs} > 32'(MAX_JUMP));
    assign at_end = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

    // One Bresenham step; SETUP feeds it the freshly computed terms.
    logic signed [12:0] st_dx, st_dy, st_err, nerr;
    logic               st_sx, st_sy, step_x, step_y;
    logic signed [13:0] e2, dx_w, dy_w;
    logic [10:0]        nx;
    logic [9:0]         ny;

    assign st_dx  = (state_q == S_SETUP) ? dx_c  : dx_q;
    assign st_dy  = (state_q == S_SETUP) ? dy_c  : dy_q;
    assign st_err = (state_q == S_SETUP) ? err_c : err_q;
    assign st_sx  = (state_q == S_SETUP) ? sx_c  : sx_q;
    assign st_sy  = (state_q == S_SETUP) ? sy_c  : sy_q;
    assign e2     = {st_err, 1'b0};
    assign dx_w   = {st_dx[12], st_dx};
    assign dy_w   = {st_dy[12], st_dy};
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);
    assign nerr   = st_err + (step_x ? st_dy : 13'sd0) + (step_y ? st_dx : 13'sd0);
    assign nx     = step_x ? (st_sx ? cur_x_q + 11'd1 : cur_x_q - 11'd1) : cur_x_q;
    assign ny     = step_y ? (st_sy ? cur_y_q + 10'd1 : cur_y_q - 10'd1) : cur_y_q;

    logic handshake;
    assign pixel_valid_out = (state_q == S_DRAW);
    assign handshake       = pixel_valid_out && pixel_ready_in;
    assign pixel_x_out     = cur_x_q;
    assign pixel_y_out     = cur_y_q;
    assign busy_out        = (state_q != S_IDLE) || pend_full_q;
    assign drop_out        = drop_q;

    always_comb begin
        state_d     = state_q;
        last_x_d    = last_x_q;
        last_y_d    = last_y_q;
        have_last_d = have_last_q;
        pend_full_d = pend_full_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_pen_d  = pend_pen_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        end_x_d     = end_x_q;
        end_y_d     = end_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        start_d     = start_q;
        drop_d      = 1'b0;

        // A strobe that cannot be consumed directly lands in the slot, evicting any older point.
        if (valid_com_in && ((state_q != S_IDLE) || pend_full_q)) begin
            pend_x_d    = x_com_in;
            pend_y_d    = y_com_in;
            pend_pen_d  = pen_down_in;
            pend_full_d = 1'b1;
            if ((state_q != S_IDLE) && pend_full_q) drop_d = 1'b1;
        end else if (take_pend) begin
            pend_full_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pt_vld) begin
                    if (pt_oor) begin
                        drop_d = 1'b1;
                    end else begin
                        last_x_d = pt_x;
                        last_y_d = pt_y;
                        if (!pt_pen) begin
                            have_last_d = 1'b0;
                        end else begin
                            have_last_d = 1'b1;
                            start_d     = !have_last_q;
                            cur_x_d     = have_last_q ? last_x_q : pt_x;
                            cur_y_d     = have_last_q ? last_y_q : pt_y;
                            end_x_d     = pt_x;
                            end_y_d     = pt_y;
                            state_d     = S_SETUP;
                        end
                    end
                end
            end
            S_SETUP: begin
                dx_d  = dx_c;
                dy_d  = dy_c;
                sx_d  = sx_c;
                sy_d  = sy_c;
                err_d = err_c;
                if (glitch) begin
                    cur_x_d = end_x_q;
                    cur_y_d = end_y_q;
                    state_d = S_DRAW;
                end else if (start_q) begin
                    state_d = S_DRAW;
                end else if (at_end) begin
                    state_d = S_IDLE;
                end else begin
                    cur_x_d = nx;
                    cur_y_d = ny;
                    err_d   = nerr;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (handshake) begin
                    if (at_end) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_x_d = nx;
                        cur_y_d = ny;
                        err_d   = nerr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            last_x_q    <= '0;
            last_y_q    <= '0;
            have_last_q <= 1'b0;
            pend_full_q <= 1'b0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_pen_q  <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            end_x_q     <= '0;
            end_y_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            start_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            have_last_q <= have_last_d;
            pend_full_q <= pend_full_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_pen_q  <= pend_pen_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            end_x_q     <= end_x_d;
            end_y_q     <= end_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            start_q     <= start_d;
            drop_q      <= drop_d;
        end
    end

endmodule
